// File: rtl/hash_host_pkg.sv
// Shared types and constants for the hash peripheral host driver.
// Counter widths are derived with cnt_width() so each counter can hold its terminal count.
package hash_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_REWIND
    } state_t;

    localparam int MSG_BYTES_DEF = 48;
    localparam int DIG_BYTES_DEF = 32;
    localparam int TIMEOUT_DEF   = 4096;
    localparam int PRST_LEN      = 2;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    localparam int PRST_CNT_W = cnt_width(PRST_LEN);

endpackage

// File: rtl/hash_host_driver.sv
// Host-side driver for a byte-serial hashing peripheral: resets it, streams the
// message in, starts it, waits for completion and streams the digest out.
module hash_host_driver
    import hash_host_pkg::*;
#(
    parameter int MSG_BYTES = MSG_BYTES_DEF,
    parameter int DIG_BYTES = DIG_BYTES_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       job_start,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    input  logic       msg_valid,
    input  logic [7:0] msg_data,
    output logic       msg_ready,
    output logic       dig_valid,
    output logic [7:0] dig_data,
    input  logic       dig_ready,
    output logic       p_rst,
    output logic       p_inputxSS,
    output logic [7:0] p_msgxSI,
    output logic       p_reg_startxSS,
    output logic       p_hash_startxSI,
    input  logic       p_hash_readyxSI,
    output logic       p_reg_outxSS,
    input  logic [7:0] p_digestxSI
);

    localparam int MW = cnt_width(MSG_BYTES);
    localparam int DW = cnt_width(DIG_BYTES);
    localparam int TW = cnt_width(TIMEOUT);

    state_t                state, next_state;
    logic [MW-1:0]         byte_cnt;
    logic [DW-1:0]         issue_cnt, cons_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [PRST_CNT_W-1:0] prst_cnt;
    logic                  rd_pend;

    logic in_hs, dig_hs, last_byte, last_dig, prst_end, tmo_abort, rd_issue;
    logic p_rst_d, p_input_d, p_start_d, p_out_d, done_d;

    assign busy      = (state != S_IDLE);
    assign msg_ready = (state == S_LOAD);
    assign in_hs     = msg_valid && msg_ready;
    assign dig_hs    = dig_valid && dig_ready;
    assign last_byte = in_hs && (byte_cnt == MW'(MSG_BYTES - 1));
    assign last_dig  = dig_hs && (cons_cnt == DW'(DIG_BYTES - 1));
    assign prst_end  = (prst_cnt == PRST_CNT_W'(PRST_LEN - 1));
    assign tmo_abort = (state == S_WAIT) && !p_hash_readyxSI && (tmo_cnt == TW'(TIMEOUT - 1));

    // A read strobe is issued only when the single-byte output buffer will be free
    // by the time its byte lands, so no captured byte can ever be overwritten.
    assign rd_issue  = (state == S_READ) && !p_reg_outxSS && !rd_pend &&
                       (!dig_valid || dig_ready) && (issue_cnt != DW'(DIG_BYTES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        next_state = state;
        case (state)
            S_IDLE:   if (job_start) next_state = S_PRST;
            S_PRST:   if (prst_end) next_state = S_LOAD;
            S_LOAD:   if (last_byte) next_state = S_START;
            S_START:  next_state = S_WAIT;
            S_WAIT:   if (p_hash_readyxSI) next_state = S_READ;
                      else if (tmo_abort) next_state = S_IDLE;
            S_READ:   if (last_dig) next_state = S_REWIND;
            S_REWIND: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Peripheral controls are decoded from next_state so the registered copies line up with the state they belong to.
    always_comb begin
        p_rst_d   = (next_state != S_PRST);
        p_input_d = in_hs;
        p_start_d = (next_state == S_START);
        p_out_d   = rd_issue || (next_state == S_REWIND);
        done_d    = (state == S_REWIND) || tmo_abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rst           <= 1'b0;
            p_inputxSS      <= 1'b0;
            p_msgxSI        <= '0;
            p_reg_startxSS  <= 1'b0;
            p_hash_startxSI <= 1'b0;
            p_reg_outxSS    <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            rd_pend         <= 1'b0;
            dig_valid       <= 1'b0;
            dig_data        <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            p_rst           <= p_rst_d;
            p_inputxSS      <= p_input_d;
            p_reg_startxSS  <= p_start_d;
            p_hash_startxSI <= p_start_d;
            p_reg_outxSS    <= p_out_d;
            done            <= done_d;
            if (in_hs) p_msgxSI <= msg_data;

            if (state == S_IDLE && job_start) timeout_err <= 1'b0;
            else if (tmo_abort)               timeout_err <= 1'b1;

            // The rewind strobe is issued outside READ, so it never produces a capture.
            rd_pend <= p_reg_outxSS && (state == S_READ);
            if (rd_pend) begin
                dig_data  <= p_digestxSI;
                dig_valid <= 1'b1;
            end else if (dig_hs) begin
                dig_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            issue_cnt <= '0;
            cons_cnt  <= '0;
            tmo_cnt   <= '0;
            prst_cnt  <= '0;
        end else begin
            prst_cnt <= (state == S_PRST) ? prst_cnt + 1'b1 : '0;
            tmo_cnt  <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
            if (state != S_LOAD) byte_cnt <= '0;
            else if (in_hs)      byte_cnt <= byte_cnt + 1'b1;
            if (state != S_READ) begin
                issue_cnt <= '0;
                cons_cnt  <= '0;
            end else begin
                if (rd_issue) issue_cnt <= issue_cnt + 1'b1;
                if (dig_hs)   cons_cnt  <= cons_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_host_driver.sv
// Randomized bench for hash_host_driver with a transaction-level peripheral model
// (message store, start/ready latency, digest pointer with rewind).
module tb_hash_host_driver;

    localparam int MSG_BYTES = 48;
    localparam int DIG_BYTES = 32;
    localparam int TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       job_start = 1'b0;
    logic       msg_valid = 1'b0;
    logic [7:0] msg_data = 8'h00;
    logic       dig_ready = 1'b0;
    logic       p_hash_readyxSI = 1'b0;
    logic [7:0] p_digestxSI = 8'h00;
    logic       busy, done, timeout_err, msg_ready, dig_valid;
    logic [7:0] dig_data, p_msgxSI;
    logic       p_rst, p_inputxSS, p_reg_startxSS, p_hash_startxSI, p_reg_outxSS;

    always #5 clk = ~clk;

    hash_host_driver #(.MSG_BYTES(MSG_BYTES), .DIG_BYTES(DIG_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .job_start(job_start), .busy(busy), .done(done),
        .timeout_err(timeout_err), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_ready(msg_ready), .dig_valid(dig_valid), .dig_data(dig_data),
        .dig_ready(dig_ready), .p_rst(p_rst), .p_inputxSS(p_inputxSS),
        .p_msgxSI(p_msgxSI), .p_reg_startxSS(p_reg_startxSS),
        .p_hash_startxSI(p_hash_startxSI), .p_hash_readyxSI(p_hash_readyxSI),
        .p_reg_outxSS(p_reg_outxSS), .p_digestxSI(p_digestxSI)
    );

    logic [25:0] out_vec;
    assign out_vec = {busy, done, timeout_err, msg_ready, dig_valid, p_inputxSS,
                      p_reg_startxSS, p_hash_startxSI, p_reg_outxSS, p_rst, dig_data, p_msgxSI};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stimulus modes and per-job observations.
    int vmode = 2, rmode = 0;
    bit js_pulse = 0, js_hold = 0, stall_arm = 0;
    int stall_left = 0;
    int cyc = 0, sent = 0;
    int n_in, n_start, n_rd, n_done, n_prst, start_cyc, done_cyc;
    bit busy_seen, te_first, te_at_done, dv_at_done;
    logic [7:0] got[$];

    // Peripheral model state.
    logic [7:0] per_msg[MSG_BYTES];
    int per_idx = 0, per_ptr = 0, per_cd = 0;
    bit per_stuck = 0;
    bit ev_rst, ev_in, ev_start, ev_rd;
    logic [7:0] ev_byte;

    task automatic step();
        bit mv, dr;
        @(negedge clk);
        cyc++;
        n_in    += int'(p_inputxSS);
        n_start += int'(p_reg_startxSS && p_hash_startxSI);
        n_rd    += int'(p_reg_outxSS);
        n_done  += int'(done);
        n_prst  += int'(!p_rst);
        if (p_reg_startxSS && p_hash_startxSI) start_cyc = cyc;
        if (done) begin
            done_cyc   = cyc;
            te_at_done = timeout_err;
            dv_at_done = dig_valid;
        end
        if (busy && !busy_seen) begin
            busy_seen = 1;
            te_first  = timeout_err;
        end
        if (stall_left > 0) begin
            check("stall_data_held", dig_data, 8'hA5);
            check("stall_valid_held", dig_valid, 1);
            check("stall_no_read_strobe", p_reg_outxSS, 0);
        end

        case (vmode)
            0:       mv = 1'b1;
            1:       mv = (cyc % 2) == 0;
            default: mv = 1'($urandom_range(0, 1));
        endcase
        msg_valid = mv;
        msg_data  = 8'(sent);
        if (mv && msg_ready) sent++;

        if (stall_left > 0) begin
            dr = 1'b0;
            stall_left--;
        end else if (stall_arm && dig_valid && got.size() == 5) begin
            dr = 1'b0;
            stall_arm  = 0;
            stall_left = 9;
        end else begin
            dr = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        dig_ready = dr;
        if (dig_valid && dr) got.push_back(dig_data);

        if (js_pulse) begin
            job_start = 1'b1;
            js_pulse  = 0;
        end else if (js_hold) begin
            job_start = !done;
            if (done) js_hold = 0;
        end else begin
            job_start = 1'b0;
        end

        ev_rst   = !p_rst;
        ev_in    = p_inputxSS;
        ev_byte  = p_msgxSI;
        ev_start = p_reg_startxSS && p_hash_startxSI;
        ev_rd    = p_reg_outxSS;

        @(posedge clk);
        #1;
        if (ev_rst) begin
            per_idx = 0;
            per_ptr = 0;
            per_cd  = 0;
            p_hash_readyxSI = 1'b0;
        end else begin
            if (ev_in) begin
                if (per_idx < MSG_BYTES) per_msg[per_idx] = ev_byte;
                per_idx++;
            end
            if (ev_start) begin
                per_cd = per_stuck ? 0 : int'($urandom_range(1, 8));
            end else if (per_cd > 0) begin
                per_cd--;
                if (per_cd == 0) p_hash_readyxSI = 1'b1;
            end
            if (ev_rd) begin
                if (per_ptr == DIG_BYTES) begin
                    p_digestxSI = 8'hEE;
                    per_ptr = 0;
                end else begin
                    p_digestxSI = 8'hA0 + 8'(per_ptr);
                    per_ptr++;
                end
            end
        end
    endtask

    task automatic run_job(input int vm, input int rm, input bit stall, input bit hold,
                           input bit stuck, input int abort_at);
        n_in = 0; n_start = 0; n_rd = 0; n_done = 0; n_prst = 0;
        start_cyc = 0; done_cyc = 0; busy_seen = 0; te_first = 1; te_at_done = 0; dv_at_done = 1;
        got.delete();
        sent = 0;
        foreach (per_msg[k]) per_msg[k] = 8'hFF;
        vmode = vm; rmode = rm; stall_arm = stall; per_stuck = stuck;
        if (hold) js_hold = 1;
        else      js_pulse = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (abort_at > 0 && sent == abort_at) return;
            if (n_done > 0) break;
        end
        vmode = 2; rmode = 0;
    endtask

    task automatic check_full_job(input string tag);
        int errs;
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_input_strobes"}, n_in, MSG_BYTES);
        check({tag, "_start_pulses"}, n_start, 1);
        check({tag, "_read_strobes"}, n_rd, DIG_BYTES + 1);
        check({tag, "_prst_cycles"}, n_prst, 2);
        check({tag, "_timeout_err"}, te_at_done, 0);
        check({tag, "_err_cleared_on_start"}, te_first, 0);
        check({tag, "_dig_valid_idle"}, dv_at_done, 0);
        check({tag, "_periph_byte_count"}, per_idx, MSG_BYTES);
        check({tag, "_periph_ptr_rewound"}, per_ptr, 0);
        errs = 0;
        for (int k = 0; k < MSG_BYTES; k++) if (per_msg[k] !== 8'(k)) errs++;
        check({tag, "_message_bytes"}, errs, 0);
        check({tag, "_digest_count"}, got.size(), DIG_BYTES);
        errs = 0;
        foreach (got[k]) if (got[k] !== 8'hA0 + 8'(k)) errs++;
        check({tag, "_digest_order"}, errs, 0);
    endtask

    initial begin
        #1;
        check("reset_outputs", 32'(out_vec), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        step();
        check("idle_p_rst_released", p_rst, 1);
        check("idle_not_busy", busy, 0);

        run_job(0, 0, 0, 0, 0, 0);
        check_full_job("basic");

        run_job(1, 1, 0, 0, 0, 0);
        check_full_job("alt_valid");

        run_job(2, 0, 1, 0, 0, 0);
        check_full_job("stall");

        run_job(2, 1, 0, 1, 0, 0);
        check_full_job("hold_start");
        n_start = 0;
        repeat (4) step();
        check("hold_no_second_job_busy", busy, 0);
        check("hold_no_second_job_start", n_start, 0);

        run_job(2, 0, 0, 0, 1, 0);
        check("tmo_done_count", n_done, 1);
        check("tmo_err_set", te_at_done, 1);
        check("tmo_read_strobes", n_rd, 0);
        check("tmo_input_strobes", n_in, MSG_BYTES);
        check("tmo_wait_cycles", done_cyc - start_cyc, TIMEOUT + 1);
        step();
        check("tmo_err_sticky", timeout_err, 1);

        run_job(2, 1, 0, 0, 0, 0);
        check_full_job("after_tmo");

        run_job(0, 0, 0, 0, 0, 20);
        rst = 1'b0;
        #1;
        check("midjob_reset_outputs", 32'(out_vec), 0);
        n_done = 0;
        msg_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        check("midjob_no_done", n_done, 0);
        check("midjob_idle_p_rst", p_rst, 1);
        check("midjob_idle_busy", busy, 0);

        run_job(2, 1, 0, 0, 0, 0);
        check_full_job("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
